ram_port_arbiter: RTL

Shares the single-port 128x8 data RAM between two requesters: the CPU core (register-file accesses from the instruction FSM) and a DMA/debug loader. The CPU has default priority. A starvation counter guarantees DMA progress, and a lock mode lets the DMA hold the port for short bursts. The block sits between both requesters and the RAM, and drives all RAM address, data and write-enable pins.

---
 rtl/ram_port_arbiter.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/ram_port_arbiter.sv
// Shares one single-port RAM between CPU (default priority) and DMA, with starvation escape and DMA burst lock.
// Grants are combinational in the request cycle; read data and rvalid follow one cycle later.
module ram_port_arbiter #(
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 8,
  parameter int MAX_WAIT = 4,
  parameter int LOCK_MAX = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic              dma_lock,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_dout
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam int LOCK_W = $clog2(LOCK_MAX + 1);

  typedef enum logic [1:0] {
    ARB      = 2'd0,
    DMA_LOCK = 2'd1,
    RELEASE  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [WAIT_W-1:0]   r_wait_cnt;
  logic [LOCK_W-1:0]   r_lock_cnt;
  logic [LOCK_W-1:0]   w_lock_inc;
  logic                w_lock_done;
  logic                w_starved;
  logic                w_cpu_gnt;
  logic                w_dma_gnt;
  logic                w_cpu_rd;
  logic                w_dma_rd;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_cpu_rvalid;
  logic                r_dma_rvalid;

  assign w_starved   = (r_wait_cnt == WAIT_W'(MAX_WAIT));
  assign w_lock_inc  = r_lock_cnt + LOCK_W'(1);
  assign w_lock_done = (w_lock_inc == LOCK_W'(LOCK_MAX));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ARB;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ARB: begin
        // The grant cycle itself is the first locked cycle.
        if (w_dma_gnt && dma_lock) begin
          w_state_nxt = (LOCK_MAX > 1) ? DMA_LOCK : RELEASE;
        end
      end
      DMA_LOCK: begin
        if (!dma_lock || w_lock_done) begin
          w_state_nxt = RELEASE;
        end
      end
      RELEASE: w_state_nxt = ARB;
      default: w_state_nxt = ARB;
    endcase
  end

  always_comb begin
    w_cpu_gnt = 1'b0;
    w_dma_gnt = 1'b0;
    case (r_state)
      ARB: begin
        w_cpu_gnt = cpu_req && !(dma_req && w_starved);
        w_dma_gnt = dma_req && !w_cpu_gnt;
      end
      DMA_LOCK: begin
        w_dma_gnt = dma_req;
      end
      RELEASE: begin
        w_cpu_gnt = cpu_req;
        w_dma_gnt = dma_req && !cpu_req;
      end
      default: begin
        w_cpu_gnt = 1'b0;
        w_dma_gnt = 1'b0;
      end
    endcase
  end

  always_comb begin
    ram_addr = '0;
    ram_din  = '0;
    ram_we   = 1'b0;
    if (w_cpu_gnt) begin
      ram_addr = cpu_addr;
      ram_din  = cpu_wdata;
      ram_we   = cpu_we;
    end else if (w_dma_gnt) begin
      ram_addr = dma_addr;
      ram_din  = dma_wdata;
      ram_we   = dma_we;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || r_state == RELEASE || !dma_req || w_dma_gnt) begin
      r_wait_cnt <= '0;
    end else if (!w_starved) begin
      r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_lock_cnt <= '0;
    end else begin
      case (r_state)
        ARB:      r_lock_cnt <= (w_dma_gnt && dma_lock) ? LOCK_W'(1) : '0;
        DMA_LOCK: r_lock_cnt <= w_lock_inc;
        default:  r_lock_cnt <= '0;
      endcase
    end
  end

  assign w_cpu_rd = w_cpu_gnt && !cpu_we;
  assign w_dma_rd = w_dma_gnt && !dma_we;

  // Reset wins over a read granted in the same cycle, so no stale rvalid escapes.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdata      <= '0;
      r_cpu_rvalid <= 1'b0;
      r_dma_rvalid <= 1'b0;
    end else begin
      r_cpu_rvalid <= w_cpu_rd;
      r_dma_rvalid <= w_dma_rd;
      if (w_cpu_rd || w_dma_rd) begin
        r_rdata <= ram_dout;
      end
    end
  end

  assign cpu_gnt    = w_cpu_gnt;
  assign dma_gnt    = w_dma_gnt;
  assign cpu_rvalid = r_cpu_rvalid;
  assign dma_rvalid = r_dma_rvalid;
  assign rdata      = r_rdata;

endmodule
